se_sram_srw_arbiter_2: RTL and testbench
========================================

Name: se_sram_srw_arbiter_2

Overview:
- Shares one single-port SRAM instance (se_sram_srw style: synchronous, 1-cycle read latency, select plus read_not_write) between two requesters.
- Arbitration is round-robin, with an optional locked burst so one requester can keep the SRAM for back-to-back accesses.
- Read data returns on a shared bus with a per-requester valid strobe.
- Sits between two client engines (for example a CPU data port and a DMA/video fetch) and one SRAM.

Parameters:
- address_width, 14, SRAM address bits.
- data_width, 8, SRAM data bits.
- max_burst, 4, maximum consecutive grants to one locked requester (1..15).

Ports:
- sram_clock  input  1  single clock for the arbiter and the attached SRAM.
- sram_clock__enable  input  1  global clock enable; when low, no state advances.
- reset_n  input  1  asynchronous, active-low reset.
- req_0 / req_1  input  1  access request.
- req_lock_0 / req_lock_1  input  1  request to keep ownership for the next access.
- req_read_not_write_0 / _1  input  1  1 = read, 0 = write.
- req_address_0 / _1  input  address_width  access address.
- req_write_data_0 / _1  input  data_width  write data.
- ack_0 / ack_1  output  1  access accepted this cycle (combinational).
- rd_valid_0 / rd_valid_1  output  1  rd_data holds this requester's read result.
- rd_data  output  data_width  shared read-return bus.
- sram_select  output  1  to SRAM select.
- sram_read_not_write  output  1  to SRAM read_not_write.
- sram_address  output  address_width  to SRAM address.
- sram_write_data  output  data_width  to SRAM write_data.
- sram_data_out  input  data_width  from SRAM data_out.

Behaviour:
- Reset (async, reset_n low), registered state is cleared:
  - last_grant=1, so requester 0 wins first.
  - owner=NONE, burst_count=0.
  - rd_pending=0, rd_tag=0.
  - Consequently ack_0/1=0, rd_valid_0/1=0, sram_select=0.
  - Reset asserted mid-burst or with a read in flight discards that read; no rd_valid is produced afterwards.
- State machine: owner in {NONE, OWN0, OWN1}.
  - NONE: if exactly one req is high, grant it. If both are high, grant the one not equal to last_grant.
  - OWNx: only requester x may be granted. If req_x is low, grant falls through to the other requester as in NONE, and owner returns to NONE.
- Grant and lock rules:
  - A granted access whose req_lock is high, with burst_count+1 < max_burst, moves owner to OWNx and increments burst_count.
  - A grant otherwise moves owner to NONE and clears burst_count.
  - Every grant sets last_grant to the winner.
- Grant cycle, combinational outputs:
  - ack of the winner = 1.
  - sram_select = 1; sram_read_not_write, sram_address and sram_write_data are muxed from the winner.
  - With no grant: sram_select=0 and the other SRAM outputs are driven from requester 0 (don't-care).
- Read return:
  - A granted read sets rd_pending=1 and rd_tag=winner at the clock edge.
  - In the next enabled cycle, rd_valid_<rd_tag>=1 and rd_data=sram_data_out (combinational pass-through).
  - Latency is 1 cycle from the ack cycle. One read returns per cycle, fully pipelined, no bubbles.
- Writes: complete at the grant edge and produce no response.
- sram_clock__enable low:
  - ack_0/1=0 and sram_select=0.
  - All state holds, and rd_valid holds its previous value. It is qualified by the enable in the client.
- Requests may change only after ack. A requester that drops req without ack loses nothing, because no access was started.
- Simultaneous events:
  - A write granted in cycle N and a read of the same address in N+1 returns the new data (SRAM ordering).
  - A lock request from the non-owner is ignored.

Decomposition:
- Shared package: owner state encoding (NONE=2'd0, OWN0=2'd1, OWN1=2'd2) and the burst-counter width constant (4 bits).
- One natural sub-module, se_arbiter_rr_2: a 2-way round-robin pick given reqs, last_grant and owner, returning the winner and a valid flag. It is purely combinational and reused by future N-port arbiters.
- Datapath muxing and the read-tag pipeline stay in the top level.

Test Plan:
- Reset release with req_0=req_1=1, reads at 0x010 and 0x020 (RAM preloaded 0x10→0xA5, 0x20→0x5A):
  - ack_0 in cycle 0, ack_1 in cycle 1.
  - rd_valid_0 with rd_data=0xA5 in cycle 1; rd_valid_1 with rd_data=0x5A in cycle 2.
- Both requesting continuously for 8 cycles, no lock -> acks alternate 0,1,0,1…, four each.
- Lock burst, req_lock_0=1 with req_1=1 and max_burst=4:
  - ack_0 for 4 consecutive cycles, then ack_1.
  - Owner returns to NONE after the 4th grant.
- Write-then-read: req_0 writes 0x3C to 0x005, then immediately reads 0x005 -> rd_valid_0 with rd_data=0x3C one cycle after the read ack.
- sram_clock__enable low for 3 cycles mid-stream:
  - No acks, sram_select=0, pending read tag preserved.
  - rd_valid occurs on the first enabled cycle.
- reset_n pulsed low during a locked burst with a read in flight:
  - Outputs clear asynchronously and no rd_valid appears after release.
  - First grant after release goes to requester 0.

Source files
------------

// File: rtl/se_sram_srw_arbiter_2_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : se_sram_srw_arbiter_2_pkg
// Brief    : Owner-state encoding and burst-counter width shared by the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package se_sram_srw_arbiter_2_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_0    = 2'd1,
        OWN_1    = 2'd2
    } owner_e;

    localparam int unsigned c_burst_cnt_w = 4;

endpackage
`default_nettype wire

// File: rtl/se_sram_srw_arbiter_2_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : se_sram_srw_arbiter_2_if
// Brief    : Requester, read-return and SRAM-side signals of the 2-way arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface se_sram_srw_arbiter_2_if #(
    parameter int ADDRESS_WIDTH = 14,
    parameter int DATA_WIDTH    = 8
);
    logic                     req_0;
    logic                     req_1;
    logic                     req_lock_0;
    logic                     req_lock_1;
    logic                     req_read_not_write_0;
    logic                     req_read_not_write_1;
    logic [ADDRESS_WIDTH-1:0] req_address_0;
    logic [ADDRESS_WIDTH-1:0] req_address_1;
    logic [DATA_WIDTH-1:0]    req_write_data_0;
    logic [DATA_WIDTH-1:0]    req_write_data_1;
    logic                     ack_0;
    logic                     ack_1;
    logic                     rd_valid_0;
    logic                     rd_valid_1;
    logic [DATA_WIDTH-1:0]    rd_data;
    logic                     sram_select;
    logic                     sram_read_not_write;
    logic [ADDRESS_WIDTH-1:0] sram_address;
    logic [DATA_WIDTH-1:0]    sram_write_data;
    logic [DATA_WIDTH-1:0]    sram_data_out;

    // The arbiter side.
    modport slave (
        input  req_0, req_1, req_lock_0, req_lock_1,
        input  req_read_not_write_0, req_read_not_write_1,
        input  req_address_0, req_address_1,
        input  req_write_data_0, req_write_data_1,
        input  sram_data_out,
        output ack_0, ack_1, rd_valid_0, rd_valid_1, rd_data,
        output sram_select, sram_read_not_write, sram_address, sram_write_data
    );

    // The clients plus SRAM side.
    modport master (
        output req_0, req_1, req_lock_0, req_lock_1,
        output req_read_not_write_0, req_read_not_write_1,
        output req_address_0, req_address_1,
        output req_write_data_0, req_write_data_1,
        output sram_data_out,
        input  ack_0, ack_1, rd_valid_0, rd_valid_1, rd_data,
        input  sram_select, sram_read_not_write, sram_address, sram_write_data
    );
endinterface
`default_nettype wire

// File: rtl/se_sram_srw_arbiter_2_rr.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : se_arbiter_rr_2
// Brief    : Combinational 2-way round-robin pick honouring a current owner.
// Revision : 1.0 - initial release
// ============================================================================
module se_arbiter_rr_2
    import se_sram_srw_arbiter_2_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic       i_last_grant,
    input  owner_e     i_owner,
    output logic       o_winner,
    output logic       o_valid
);

    always_comb begin
        o_winner = 1'b0;
        o_valid  = 1'b0;
        if ((i_owner == OWN_0) && i_req[0]) begin
            o_winner = 1'b0;
            o_valid  = 1'b1;
        end else if ((i_owner == OWN_1) && i_req[1]) begin
            o_winner = 1'b1;
            o_valid  = 1'b1;
        end else if (&i_req) begin
            // Contention: whoever did not win last time goes next.
            o_winner = ~i_last_grant;
            o_valid  = 1'b1;
        end else if (i_req[1]) begin
            o_winner = 1'b1;
            o_valid  = 1'b1;
        end else if (i_req[0]) begin
            o_winner = 1'b0;
            o_valid  = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/se_sram_srw_arbiter_2.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : se_sram_srw_arbiter_2
// Brief    : Shares one single-port sync SRAM between two requesters (RR + lock).
// Revision : 1.0 - initial release
// ============================================================================
module se_sram_srw_arbiter_2 #(
    parameter int ADDRESS_WIDTH = 14,
    parameter int DATA_WIDTH    = 8,
    parameter int MAX_BURST     = 4
) (
    input  logic                   sram_clock,
    input  logic                   sram_clock__enable,
    input  logic                   reset_n,
    se_sram_srw_arbiter_2_if.slave bus
);
    import se_sram_srw_arbiter_2_pkg::*;

    localparam logic [c_burst_cnt_w:0] c_max_burst = MAX_BURST[c_burst_cnt_w:0];

    owner_e                   owner_q, owner_d;
    logic [c_burst_cnt_w-1:0] burst_count_q, burst_count_d;
    logic                     last_grant_q, last_grant_d;
    logic                     rd_pending_q, rd_pending_d;
    logic                     rd_tag_q, rd_tag_d;

    logic                     w_winner;
    logic                     w_arb_valid;
    logic                     w_grant;
    logic                     w_win_lock;
    logic                     w_win_rnw;
    logic                     w_lock_allowed;
    logic [c_burst_cnt_w:0]   w_burst_inc;
    logic [ADDRESS_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0]    w_wdata;

    se_arbiter_rr_2 u_rr (
        .i_req        ({bus.req_1, bus.req_0}),
        .i_last_grant (last_grant_q),
        .i_owner      (owner_q),
        .o_winner     (w_winner),
        .o_valid      (w_arb_valid)
    );

    // No grant while stalled or while reset is asserted, even with requests up.
    assign w_grant     = sram_clock__enable & reset_n & w_arb_valid;
    assign w_win_lock  = w_winner ? bus.req_lock_1 : bus.req_lock_0;
    assign w_win_rnw   = w_winner ? bus.req_read_not_write_1 : bus.req_read_not_write_0;
    assign w_burst_inc = {1'b0, burst_count_q} + 1'b1;

    // A winner that merely fell through past an idle owner cannot start a lock.
    assign w_lock_allowed = (owner_q == OWN_NONE) ||
                            ((owner_q == OWN_0) && !w_winner) ||
                            ((owner_q == OWN_1) &&  w_winner);

    always_comb begin
        owner_d       = owner_q;
        burst_count_d = burst_count_q;
        last_grant_d  = last_grant_q;
        rd_pending_d  = rd_pending_q;
        rd_tag_d      = rd_tag_q;
        if (sram_clock__enable) begin
            rd_pending_d = w_grant & w_win_rnw;
            if (w_grant && w_win_rnw) begin
                rd_tag_d = w_winner;
            end
            if (w_grant) begin
                last_grant_d = w_winner;
                if (w_win_lock && w_lock_allowed && (w_burst_inc < c_max_burst)) begin
                    owner_d       = w_winner ? OWN_1 : OWN_0;
                    burst_count_d = w_burst_inc[c_burst_cnt_w-1:0];
                end else begin
                    owner_d       = OWN_NONE;
                    burst_count_d = '0;
                end
            end else begin
                // No grant means any owner has dropped its request.
                owner_d       = OWN_NONE;
                burst_count_d = '0;
            end
        end
    end

    always_ff @(posedge sram_clock or negedge reset_n) begin
        if (!reset_n) begin
            owner_q       <= OWN_NONE;
            burst_count_q <= '0;
            last_grant_q  <= 1'b1;
            rd_pending_q  <= 1'b0;
            rd_tag_q      <= 1'b0;
        end else begin
            owner_q       <= owner_d;
            burst_count_q <= burst_count_d;
            last_grant_q  <= last_grant_d;
            rd_pending_q  <= rd_pending_d;
            rd_tag_q      <= rd_tag_d;
        end
    end

    assign w_addr  = (w_grant && w_winner) ? bus.req_address_1    : bus.req_address_0;
    assign w_wdata = (w_grant && w_winner) ? bus.req_write_data_1 : bus.req_write_data_0;

    assign bus.ack_0               = w_grant & ~w_winner;
    assign bus.ack_1               = w_grant &  w_winner;
    assign bus.sram_select         = w_grant;
    assign bus.sram_read_not_write = (w_grant && w_winner) ? bus.req_read_not_write_1
                                                           : bus.req_read_not_write_0;
    assign bus.sram_address        = w_addr;
    assign bus.sram_write_data     = w_wdata;

    assign bus.rd_valid_0 = rd_pending_q & ~rd_tag_q;
    assign bus.rd_valid_1 = rd_pending_q &  rd_tag_q;
    assign bus.rd_data    = bus.sram_data_out;

endmodule
`default_nettype wire

// File: tb/tb_se_sram_srw_arbiter_2.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_se_sram_srw_arbiter_2
// Brief    : Directed bench with an attached SRAM and a rule-level arbiter model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_se_sram_srw_arbiter_2;
    localparam int AW = 14;
    localparam int DW = 8;
    localparam int MB = 4;

    logic clk = 1'b0;
    logic en;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    se_sram_srw_arbiter_2_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    se_sram_srw_arbiter_2 #(
        .ADDRESS_WIDTH (AW),
        .DATA_WIDTH    (DW),
        .MAX_BURST     (MB)
    ) dut (
        .sram_clock         (clk),
        .sram_clock__enable (en),
        .reset_n            (rst_n),
        .bus                (bus.slave)
    );

    always #5 clk = ~clk;

    // Attached single-port SRAM: one access per enabled edge, 1-cycle read.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (!rst_n) begin
            mem[14'h010] <= 8'hA5;
            mem[14'h020] <= 8'h5A;
        end else if (en && bus.sram_select) begin
            if (bus.sram_read_not_write) bus.sram_data_out <= mem[bus.sram_address];
            else                         mem[bus.sram_address] <= bus.sram_write_data;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: ownership, turn-taking and outstanding read by rule.
    int            m_last, m_owner, m_count, m_w, m_ptag;
    bit            m_pv, m_rnw, m_lock;
    logic [DW-1:0] m_pdata;
    logic [DW-1:0] m_mem [int];
    int            m_addr;
    bit            rq0, rq1;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_ack_0", bus.ack_0, 0);
            chk("rst_ack_1", bus.ack_1, 0);
            chk("rst_rd_valid_0", bus.rd_valid_0, 0);
            chk("rst_rd_valid_1", bus.rd_valid_1, 0);
            chk("rst_sram_select", bus.sram_select, 0);
            m_last = 1; m_owner = -1; m_count = 0; m_pv = 0; m_ptag = 0;
            m_mem[32'h010] = 8'hA5;
            m_mem[32'h020] = 8'h5A;
        end else begin
            rq0 = (bus.req_0 === 1'b1);
            rq1 = (bus.req_1 === 1'b1);
            m_w = -1;
            if (en) begin
                if (m_owner == 0 && rq0)      m_w = 0;
                else if (m_owner == 1 && rq1) m_w = 1;
                else if (rq0 && rq1)          m_w = 1 - m_last;
                else if (rq0)                 m_w = 0;
                else if (rq1)                 m_w = 1;
            end
            m_rnw  = (m_w == 1) ? bus.req_read_not_write_1 : bus.req_read_not_write_0;
            m_addr = (m_w == 1) ? int'(bus.req_address_1) : int'(bus.req_address_0);
            m_lock = (m_w == 1) ? bus.req_lock_1 : bus.req_lock_0;
            chk("m_ack_0", bus.ack_0, m_w == 0);
            chk("m_ack_1", bus.ack_1, m_w == 1);
            chk("m_sram_select", bus.sram_select, m_w >= 0);
            if (m_w >= 0) begin
                chk("m_sram_address", bus.sram_address, m_addr);
                chk("m_sram_rnw", bus.sram_read_not_write, m_rnw);
                if (!m_rnw)
                    chk("m_sram_wdata", bus.sram_write_data,
                        (m_w == 1) ? bus.req_write_data_1 : bus.req_write_data_0);
            end
            chk("m_rd_valid_0", bus.rd_valid_0, m_pv && m_ptag == 0);
            chk("m_rd_valid_1", bus.rd_valid_1, m_pv && m_ptag == 1);
            if (m_pv) chk("m_rd_data", bus.rd_data, m_pdata);
            if (en) begin
                if (m_w >= 0) begin
                    if (m_rnw) begin
                        m_pv = 1; m_ptag = m_w; m_pdata = m_mem[m_addr];
                    end else begin
                        m_pv = 0; m_mem[m_addr] = (m_w == 1) ? bus.req_write_data_1
                                                              : bus.req_write_data_0;
                    end
                    if (m_lock && (m_owner == -1 || m_owner == m_w) && m_count + 1 < MB) begin
                        m_owner = m_w; m_count = m_count + 1;
                    end else begin
                        m_owner = -1; m_count = 0;
                    end
                    m_last = m_w;
                end else begin
                    m_pv = 0; m_owner = -1; m_count = 0;
                end
            end
        end
    end

    task automatic set0(input logic r, input logic lk, input logic rnw,
                        input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.req_0 = r; bus.req_lock_0 = lk; bus.req_read_not_write_0 = rnw;
        bus.req_address_0 = a; bus.req_write_data_0 = d;
    endtask

    task automatic set1(input logic r, input logic lk, input logic rnw,
                        input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.req_1 = r; bus.req_lock_1 = lk; bus.req_read_not_write_1 = rnw;
        bus.req_address_1 = a; bus.req_write_data_1 = d;
    endtask

    task automatic idle();
        set0(0, 0, 1, '0, '0);
        set1(0, 0, 1, '0, '0);
    endtask

    task automatic nxt();
        @(posedge clk); #1;
    endtask

    task automatic mid();
        @(negedge clk); #1;
    endtask

    int c0, c1;

    initial begin
        en = 1'b1; rst_n = 1'b0; idle();
        repeat (3) @(posedge clk);
        #1;

        // Release from reset with both requesters reading
        set0(1, 0, 1, 14'h010, 8'h00);
        set1(1, 0, 1, 14'h020, 8'h00);
        #1 rst_n = 1'b1;
        mid(); chk("t1_ack0_c0", bus.ack_0, 1); chk("t1_ack1_c0", bus.ack_1, 0);
        nxt(); set0(0, 0, 1, '0, '0);
        mid(); chk("t1_ack1_c1", bus.ack_1, 1); chk("t1_rdv0_c1", bus.rd_valid_0, 1);
        chk("t1_rdata_c1", bus.rd_data, 8'hA5);
        nxt(); set1(0, 0, 1, '0, '0);
        mid(); chk("t1_rdv1_c2", bus.rd_valid_1, 1); chk("t1_rdata_c2", bus.rd_data, 8'h5A);
        nxt();

        // Continuous contention, no lock
        set0(1, 0, 1, 14'h010, 8'h00);
        set1(1, 0, 1, 14'h020, 8'h00);
        c0 = 0; c1 = 0;
        for (int i = 0; i < 8; i++) begin
            mid();
            chk("t2_alt_ack0", bus.ack_0, (i % 2) == 0);
            c0 += int'(bus.ack_0); c1 += int'(bus.ack_1);
            nxt();
        end
        idle();
        chk("t2_count0", c0, 4); chk("t2_count1", c1, 4);
        mid(); nxt();

        // Locked burst from requester 0 against a waiting requester 1
        set0(1, 1, 1, 14'h010, 8'h00);
        set1(1, 0, 1, 14'h020, 8'h00);
        for (int i = 0; i < 5; i++) begin
            mid();
            chk("t3_burst_ack0", bus.ack_0, i < 4);
            chk("t3_burst_ack1", bus.ack_1, i == 4);
            nxt();
        end
        idle(); mid(); nxt();

        // Write then read the same address
        set0(1, 0, 0, 14'h005, 8'h3C);
        mid(); chk("t4_wr_ack", bus.ack_0, 1); chk("t4_wr_rnw", bus.sram_read_not_write, 0);
        nxt(); set0(1, 0, 1, 14'h005, 8'h00);
        mid(); chk("t4_rd_ack", bus.ack_0, 1);
        nxt(); idle();
        mid(); chk("t4_rdv0", bus.rd_valid_0, 1); chk("t4_rdata", bus.rd_data, 8'h3C);
        nxt();

        // Clock enable low for three cycles with a read outstanding
        set0(1, 0, 1, 14'h010, 8'h00);
        mid(); chk("t5_ack0", bus.ack_0, 1);
        nxt(); set0(0, 0, 1, '0, '0); set1(1, 0, 1, 14'h020, 8'h00); en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mid();
            chk("t5_stall_ack0", bus.ack_0, 0); chk("t5_stall_ack1", bus.ack_1, 0);
            chk("t5_stall_sel", bus.sram_select, 0); chk("t5_stall_rdv0", bus.rd_valid_0, 1);
            nxt();
        end
        en = 1'b1;
        mid(); chk("t5_resume_rdv0", bus.rd_valid_0, 1); chk("t5_resume_rdata", bus.rd_data, 8'hA5);
        chk("t5_resume_ack1", bus.ack_1, 1);
        nxt(); set1(0, 0, 1, '0, '0);
        mid(); chk("t5_rdv1", bus.rd_valid_1, 1); chk("t5_rdata1", bus.rd_data, 8'h5A);
        nxt();

        // Reset pulse during a locked burst with a read in flight
        set0(1, 1, 1, 14'h010, 8'h00);
        set1(1, 0, 1, 14'h020, 8'h00);
        mid(); chk("t6_ack0_a", bus.ack_0, 1);
        nxt();
        mid(); chk("t6_ack0_b", bus.ack_0, 1);
        nxt();
        #1 rst_n = 1'b0;
        #1;
        chk("t6_async_ack0", bus.ack_0, 0); chk("t6_async_ack1", bus.ack_1, 0);
        chk("t6_async_rdv0", bus.rd_valid_0, 0); chk("t6_async_sel", bus.sram_select, 0);
        @(posedge clk); #2 rst_n = 1'b1;
        mid(); chk("t6_first_ack0", bus.ack_0, 1); chk("t6_first_ack1", bus.ack_1, 0);
        chk("t6_no_rdv0", bus.rd_valid_0, 0); chk("t6_no_rdv1", bus.rd_valid_1, 0);
        nxt(); idle();
        mid(); nxt();
        repeat (2) nxt();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
